// File: rtl/barrier_token_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : barrier_token_ctrl
//  Purpose  : N-way join controller for a barrier queue stage placed directly
//             downstream. One token counter per producer stream counts
//             completed frames. The barrier enable opens once every source
//             holds at least one token. Each frame released by the queue
//             consumes one token from every source.
//
//  Parameters
//    NUM_SRC        : number of producer streams joined (>= 1)
//    CNT_WIDTH      : per-source token counter width (max 2**CNT_WIDTH-1)
//    TIMEOUT_CYCLES : partial-barrier stall limit (timeout build only)
//
//  Ports
//    clk          in  : clock
//    rst          in  : asynchronous active-high reset (sync release upstream)
//    src_done     in  : per-source one-cycle pulse, one frame completed
//    src_ready    out : per-source, counter can take a token this cycle
//    release_done in  : one-cycle pulse, queue released one frame
//    barrier      out : gate enable to the barrier queue (registered)
//    token_cnt    out : packed counters, src i at [i*CNT_WIDTH +: CNT_WIDTH]
//    err_overflow out : sticky, a token was dropped on a saturated counter
//    err_proto    out : sticky, release_done seen while barrier was low
//    err_timeout  out : sticky, partial barrier stalled for TIMEOUT_CYCLES
//
//  Configuration macro
//    BARRIER_TIMEOUT_EN : builds the stall counter that drives err_timeout.
//                         When undefined, err_timeout is tied low.
//
//  Revision : 1.0  initial release
// ============================================================================
module barrier_token_ctrl #(
    parameter int unsigned NUM_SRC        = 2,
    parameter int unsigned CNT_WIDTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SRC-1:0]             src_done,
    output logic [NUM_SRC-1:0]             src_ready,
    input  logic                           release_done,
    output logic                           barrier,
    output logic [NUM_SRC*CNT_WIDTH-1:0]   token_cnt,
    output logic                           err_overflow,
    output logic                           err_proto,
    output logic                           err_timeout
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [0:0]           c_ST_WAIT  = 1'b0;
    localparam logic [0:0]           c_ST_OPEN  = 1'b1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [0:0]           state_q;
    logic [0:0]           state_d;
    logic [CNT_WIDTH-1:0] cnt_q [NUM_SRC];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_SRC];
    logic [NUM_SRC-1:0]   w_inc;
    logic [NUM_SRC-1:0]   w_nz_q;
    logic [NUM_SRC-1:0]   w_nz_d;
    logic                 w_dec;
    logic                 w_all_nz_d;
    logic                 w_any_nz_q;
    logic                 err_overflow_q;
    logic                 err_overflow_d;
    logic                 err_proto_q;
    logic                 err_proto_d;

    // A release only counts while the barrier is open; in WAIT every counter
    // may legitimately be zero, so decrementing there would underflow.
    assign w_dec = release_done & (state_q == c_ST_OPEN);

    // ------------------------------------------------------------------------
    // Per-source token counters
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < int'(NUM_SRC); gi++) begin : g_src
        // A saturated counter can still accept a token in a release cycle,
        // since the common decrement frees a slot in the same clock.
        assign src_ready[gi] = (cnt_q[gi] != c_CNT_MAX) | w_dec;
        assign w_inc[gi]     = src_done[gi] & src_ready[gi];

        always_comb begin
            cnt_d[gi] = cnt_q[gi];
            if (w_inc[gi] && !w_dec) begin
                cnt_d[gi] = cnt_q[gi] + c_CNT_ONE;
            end else if (!w_inc[gi] && w_dec) begin
                cnt_d[gi] = cnt_q[gi] - c_CNT_ONE;
            end
        end

        assign w_nz_q[gi] = (cnt_q[gi] != c_CNT_ZERO);
        assign w_nz_d[gi] = (cnt_d[gi] != c_CNT_ZERO);

        assign token_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_q[gi];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q[gi] <= c_CNT_ZERO;
            end else begin
                cnt_q[gi] <= cnt_d[gi];
            end
        end
    end

    assign w_all_nz_d = &w_nz_d;
    assign w_any_nz_q = |w_nz_q;

    // ------------------------------------------------------------------------
    // Barrier FSM
    // ------------------------------------------------------------------------
    // Decisions use the next counter values so that a token arriving in the
    // same cycle as a release keeps the barrier open without a bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_WAIT: begin
                if (w_all_nz_d) begin
                    state_d = c_ST_OPEN;
                end
            end
            c_ST_OPEN: begin
                if (w_dec && !w_all_nz_d) begin
                    state_d = c_ST_WAIT;
                end
            end
            default: state_d = c_ST_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_ST_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    assign barrier = (state_q == c_ST_OPEN);

    // ------------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------------
    always_comb begin
        err_overflow_d = err_overflow_q | (|(src_done & ~src_ready));
        err_proto_d    = err_proto_q | (release_done & (state_q == c_ST_WAIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_overflow_q <= 1'b0;
            err_proto_q    <= 1'b0;
        end else begin
            err_overflow_q <= err_overflow_d;
            err_proto_q    <= err_proto_d;
        end
    end

    assign err_overflow = err_overflow_q;
    assign err_proto    = err_proto_q;

    // ------------------------------------------------------------------------
    // Partial-barrier stall timeout
    // ------------------------------------------------------------------------
`ifdef BARRIER_TIMEOUT_EN
    localparam int unsigned          c_STALL_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_STALL_W-1:0] c_STALL_LIMIT = c_STALL_W'(TIMEOUT_CYCLES);
    localparam logic [c_STALL_W-1:0] c_STALL_ONE   = c_STALL_W'(1);

    logic [c_STALL_W-1:0] stall_q;
    logic [c_STALL_W-1:0] stall_d;
    logic                 err_timeout_q;
    logic                 err_timeout_d;

    // Counts only while some tokens are parked and the join is still missing
    // a source; opening the barrier or draining to empty restarts it.
    always_comb begin
        stall_d = '0;
        if ((state_q == c_ST_WAIT) && (state_d == c_ST_WAIT) && w_any_nz_q) begin
            stall_d = stall_q;
            if (stall_q != c_STALL_LIMIT) begin
                stall_d = stall_q + c_STALL_ONE;
            end
        end
        // Flag in the same clock the limit is reached, not one cycle later.
        err_timeout_d = err_timeout_q | (stall_d == c_STALL_LIMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q       <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            stall_q       <= stall_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0) & w_any_nz_q;
    assign err_timeout      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_barrier_token_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_barrier_token_ctrl
//  Purpose  : Directed scoreboard bench for barrier_token_ctrl with
//             NUM_SRC=2, CNT_WIDTH=2, TIMEOUT_CYCLES=16. The stimulus process
//             queues the expected outputs for a cycle; a monitor samples the
//             DUT on the falling edge and pops/compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_barrier_token_ctrl;

    localparam int unsigned NSRC = 2;
    localparam int unsigned CW   = 2;
    localparam int unsigned TMO  = 16;

`ifdef BARRIER_TIMEOUT_EN
    localparam logic TMO_ON = 1'b1;
`else
    localparam logic TMO_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NSRC-1:0]      src_done;
    logic [NSRC-1:0]      src_ready;
    logic                 release_done;
    logic                 barrier;
    logic [NSRC*CW-1:0]   token_cnt;
    logic                 err_overflow;
    logic                 err_proto;
    logic                 err_timeout;

    barrier_token_ctrl #(
        .NUM_SRC        (NSRC),
        .CNT_WIDTH      (CW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_done     (src_done),
        .src_ready    (src_ready),
        .release_done (release_done),
        .barrier      (barrier),
        .token_cnt    (token_cnt),
        .err_overflow (err_overflow),
        .err_proto    (err_proto),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        string      name;
        logic       bar;
        logic [3:0] cnt;   // {cnt1, cnt0}
        logic [1:0] rdy;
        logic [2:0] err;   // {timeout, proto, overflow}
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    exp_t m_e;

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at <= cyc) begin
            m_e = q.pop_front();
            checks++;
            if (m_e.at != cyc) begin
                errors++;
                $display("FAIL %s: checked at cycle %0d, required cycle %0d", m_e.name, cyc, m_e.at);
            end else if ({barrier, token_cnt, src_ready, err_timeout, err_proto, err_overflow} !==
                         {m_e.bar, m_e.cnt, m_e.rdy, m_e.err}) begin
                errors++;
                $display("FAIL %s: got barrier=%b cnt=%b ready=%b err=%b, required barrier=%b cnt=%b ready=%b err=%b",
                         m_e.name, barrier, token_cnt, src_ready,
                         {err_timeout, err_proto, err_overflow},
                         m_e.bar, m_e.cnt, m_e.rdy, m_e.err);
            end
        end
    end

    // Queue an expectation for the cycle currently being driven.
    task automatic expect_now(input string nm, input logic bar, input logic [3:0] cnt,
                              input logic [1:0] rdy, input logic [2:0] err);
        exp_t e;
        e.at   = cyc;
        e.name = nm;
        e.bar  = bar;
        e.cnt  = cnt;
        e.rdy  = rdy;
        e.err  = err;
        q.push_back(e);
    endtask

    // Apply inputs for one full cycle, starting just after the rising edge.
    task automatic drive(input logic [1:0] sd, input logic rel);
        @(posedge clk);
        #1;
        src_done     = sd;
        release_done = rel;
    endtask

    initial begin
        rst          = 1'b1;
        src_done     = '0;
        release_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        expect_now("reset_state", 1'b0, 4'b0000, 2'b11, 3'b000);

        // Join: src0 at t0, src1 at t5, barrier at t6, release at t8.
        drive(2'b01, 1'b0); expect_now("join_t0",   1'b0, 4'b0000, 2'b11, 3'b000);
        drive(2'b00, 1'b0); expect_now("join_t1",   1'b0, 4'b0001, 2'b11, 3'b000);
        drive(2'b00, 1'b0);
        drive(2'b00, 1'b0);
        drive(2'b00, 1'b0);
        drive(2'b10, 1'b0); expect_now("join_t5",   1'b0, 4'b0001, 2'b11, 3'b000);
        drive(2'b00, 1'b0); expect_now("join_t6",   1'b1, 4'b0101, 2'b11, 3'b000);
        drive(2'b00, 1'b0);
        drive(2'b00, 1'b1); expect_now("join_rel",  1'b1, 4'b0101, 2'b11, 3'b000);
        drive(2'b00, 1'b0); expect_now("join_t9",   1'b0, 4'b0000, 2'b11, 3'b000);

        // Back-to-back releases from cnt={2,3}; src1 full but refilled by dec.
        drive(2'b11, 1'b0);
        drive(2'b11, 1'b0); expect_now("b2b_fill",  1'b1, 4'b0101, 2'b11, 3'b000);
        drive(2'b10, 1'b0);
        drive(2'b00, 1'b1); expect_now("b2b_rel0",  1'b1, 4'b1110, 2'b11, 3'b000);
        drive(2'b00, 1'b1); expect_now("b2b_rel1",  1'b1, 4'b1001, 2'b11, 3'b000);
        drive(2'b00, 1'b0); expect_now("b2b_close", 1'b0, 4'b0100, 2'b11, 3'b000);

        // Simultaneous token and release at cnt={1,1}.
        drive(2'b01, 1'b0);
        drive(2'b11, 1'b1); expect_now("simul_pre",  1'b1, 4'b0101, 2'b11, 3'b000);
        drive(2'b00, 1'b0); expect_now("simul_post", 1'b1, 4'b0101, 2'b11, 3'b000);

        // Saturation of src0 (max 3), then a release in WAIT.
        drive(2'b00, 1'b1);
        drive(2'b01, 1'b0); expect_now("sat_empty", 1'b0, 4'b0000, 2'b11, 3'b000);
        drive(2'b01, 1'b0);
        drive(2'b01, 1'b0);
        drive(2'b01, 1'b0); expect_now("sat_full",  1'b0, 4'b0011, 2'b10, 3'b000);
        drive(2'b00, 1'b0); expect_now("sat_ovf",   1'b0, 4'b0011, 2'b10, 3'b001);
        drive(2'b00, 1'b1); expect_now("proto_pre", 1'b0, 4'b0011, 2'b10, 3'b001);
        drive(2'b00, 1'b0); expect_now("proto_err", 1'b0, 4'b0011, 2'b10, 3'b011);

        // Reach OPEN with cnt={3,2}, then assert reset mid-cycle.
        drive(2'b10, 1'b0);
        drive(2'b10, 1'b0); expect_now("pre_rst_open", 1'b1, 4'b0111, 2'b10, 3'b011);
        drive(2'b00, 1'b0); expect_now("pre_rst_full", 1'b1, 4'b1011, 2'b10, 3'b011);
        @(posedge clk);
        #1;
        rst = 1'b1;
        expect_now("async_rst", 1'b0, 4'b0000, 2'b11, 3'b000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_now("post_rst", 1'b0, 4'b0000, 2'b11, 3'b000);

        // Partial barrier stall: src0 only, then idle.
        drive(2'b01, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            drive(2'b00, 1'b0);
            if (k == 16) expect_now("tmo_before", 1'b0, 4'b0001, 2'b11, 3'b000);
            if (k == 17) expect_now("tmo_at",     1'b0, 4'b0001, 2'b11, {TMO_ON, 2'b00});
            if (k == 20) expect_now("tmo_sticky", 1'b0, 4'b0001, 2'b11, {TMO_ON, 2'b00});
        end

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d unchecked entries, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got time limit expiry, required completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
